// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   - Default data / register-index widths.
//   - Width of the starvation age counter (holds limits up to 7).
//   - NORMAL / FORCE arbitration state encoding.
package regfile_write_arbiter_pkg;

  localparam int IALU_WORD_WIDTH_DEF = 16;
  localparam int REG_IDX_WIDTH_DEF   = 4;
  localparam int AGE_W               = 3;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_result_fifo.sv
// Synchronous FIFO holding multi-cycle results (data + destination index).
// No bypass: an entry pushed at edge N appears at the head from N+1.
// A push while full is dropped, even if a pop happens in the same cycle.
// Ports:
//   clock, reset      - clock, synchronous active-high reset (empties FIFO)
//   push_i            - enqueue request (ignored when full)
//   push_data_i/idx_i - entry to enqueue
//   pop_i             - dequeue the head (ignored when empty)
//   full_o, empty_o   - occupancy flags
//   head_data_o/idx_o - current head entry (valid when !empty_o)
module rf_result_fifo #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [IDX_W-1:0]  push_idx_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [IDX_W-1:0]  head_idx_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_data_o = data_q[rd_ptr_q];
  assign head_idx_o  = idx_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= push_data_i;
      idx_q[wr_ptr_q]  <= push_idx_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single register-file write port, shared between the in-order
// writeback stage and late-returning multi-cycle results buffered in a FIFO.
// Writeback wins by default; the FIFO head wins on a same-index conflict
// (it is older) and after being starved for STARVE_LIMIT cycles.
// Ports:
//   clock, reset                  - clock, synchronous active-high reset
//   in_wb_act/res/reg_idx         - writeback write request
//   out_wb_stall                  - writeback not taken this cycle; hold inputs
//   in_mc_valid/res/reg_idx       - multi-cycle result offer
//   out_mc_ready                  - FIFO accepts the offer this cycle
//   out_mc_pending                - FIFO holds at least one entry
//   out_rf_we/data/idx            - registered register-file write port
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = IALU_WORD_WIDTH_DEF,
  parameter int REG_IDX_WIDTH   = REG_IDX_WIDTH_DEF,
  parameter int FIFO_DEPTH      = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_wb_act,
  input  logic [IALU_WORD_WIDTH-1:0] in_wb_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_wb_reg_idx,
  output logic                       out_wb_stall,
  input  logic                       in_mc_valid,
  input  logic [IALU_WORD_WIDTH-1:0] in_mc_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_mc_reg_idx,
  output logic                       out_mc_ready,
  output logic                       out_mc_pending,
  output logic                       out_rf_we,
  output logic [IALU_WORD_WIDTH-1:0] out_rf_data,
  output logic [REG_IDX_WIDTH-1:0]   out_rf_idx
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + 1'b1;
  endfunction

  logic                       fifo_full, fifo_empty, mc_push;
  logic [IALU_WORD_WIDTH-1:0] head_res;
  logic [REG_IDX_WIDTH-1:0]   head_idx;
  logic                       grant_wb, grant_mc;
  arb_state_e                 state_q;
  logic [AGE_W-1:0]           age_q, age_d;

  assign out_mc_ready   = ~fifo_full & ~reset;
  assign mc_push        = in_mc_valid & out_mc_ready;
  assign out_mc_pending = ~fifo_empty;

  rf_result_fifo #(
    .DATA_W (IALU_WORD_WIDTH),
    .IDX_W  (REG_IDX_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (mc_push),
    .push_data_i (in_mc_res),
    .push_idx_i  (in_mc_reg_idx),
    .pop_i       (grant_mc),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_data_o (head_res),
    .head_idx_o  (head_idx)
  );

  // A head writing the same register as writeback is older, so it must land
  // first to preserve write-after-write order.
  always_comb begin
    grant_wb = 1'b0;
    grant_mc = 1'b0;
    if (!reset) begin
      if (state_q == ST_FORCE) begin
        grant_mc = ~fifo_empty;
      end else if (in_wb_act) begin
        if (!fifo_empty && (head_idx == in_wb_reg_idx)) grant_mc = 1'b1;
        else                                            grant_wb = 1'b1;
      end else begin
        grant_mc = ~fifo_empty;
      end
    end
  end

  assign out_wb_stall = in_wb_act & ~grant_wb & ~reset;

  // Age counts consecutive cycles the head is denied.
  always_comb begin
    if (fifo_empty || grant_mc) age_d = '0;
    else                        age_d = sat_inc(age_q);
  end

  // FORCE is entered on the edge where the age reaches the limit, so the
  // head is denied exactly STARVE_LIMIT cycles before the forced grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      age_q       <= '0;
      out_rf_we   <= 1'b0;
      out_rf_data <= '0;
      out_rf_idx  <= '0;
    end else begin
      age_q <= age_d;
      if (state_q == ST_FORCE)  state_q <= ST_NORMAL;
      else if (age_d == LIMIT)  state_q <= ST_FORCE;
      out_rf_we <= grant_wb | grant_mc;
      if (grant_wb) begin
        out_rf_data <= in_wb_res;
        out_rf_idx  <= in_wb_reg_idx;
      end else if (grant_mc) begin
        out_rf_data <= head_res;
        out_rf_idx  <= head_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clock, reset;
  logic        in_wb_act, in_mc_valid;
  logic [15:0] in_wb_res, in_mc_res;
  logic [3:0]  in_wb_reg_idx, in_mc_reg_idx;
  logic        out_wb_stall, out_mc_ready, out_mc_pending, out_rf_we;
  logic [15:0] out_rf_data;
  logic [3:0]  out_rf_idx;

  regfile_write_arbiter #(
    .IALU_WORD_WIDTH (16),
    .REG_IDX_WIDTH   (4),
    .FIFO_DEPTH      (DEPTH),
    .STARVE_LIMIT    (LIM)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_wb_act      (in_wb_act),
    .in_wb_res      (in_wb_res),
    .in_wb_reg_idx  (in_wb_reg_idx),
    .out_wb_stall   (out_wb_stall),
    .in_mc_valid    (in_mc_valid),
    .in_mc_res      (in_mc_res),
    .in_mc_reg_idx  (in_mc_reg_idx),
    .out_mc_ready   (out_mc_ready),
    .out_mc_pending (out_mc_pending),
    .out_rf_we      (out_rf_we),
    .out_rf_data    (out_rf_data),
    .out_rf_idx     (out_rf_idx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [15:0] d; logic [3:0] i; int t; } wr_t;
  typedef struct { logic [15:0] d; logic [3:0] i; } ent_t;

  wr_t  exp_q[$];
  ent_t mcq[$];
  int   streak;
  bit   forcing;
  int   edge_cnt;
  int   total, bad;
  logic dut_stall, dut_rdy, dut_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, req, edge_cnt);
    end
  endtask

  // Write-port monitor: every write must match the oldest expected write,
  // including the edge on which it was due.
  initial begin
    logic rst_at_edge;
    wr_t  e;
    forever begin
      @(posedge clock);
      rst_at_edge = reset;
      edge_cnt++;
      #1;
      if (rst_at_edge) begin
        chk("rst_out", {15'd0, out_rf_we, out_rf_data}, 32'd0);
        chk("rst_idx", 32'(out_rf_idx), 32'd0);
      end else if (out_rf_we) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", 32'(out_rf_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(out_rf_data), 32'(e.d));
          chk("wr_idx", 32'(out_rf_idx), 32'(e.i));
          chk("wr_lat", 32'(edge_cnt), 32'(e.t));
        end
      end
    end
  end

  // One cycle: drive inputs, check combinational outputs against the
  // reference model, then advance the model past the coming edge.
  task automatic step(input logic rst, input logic wa, input logic [15:0] wr,
                      input logic [3:0] wi, input logic mv, input logic [15:0] mr,
                      input logic [3:0] mi, output logic stl, output logic rdy);
    logic e_rdy, e_stl, e_pend, gwb, gmc;
    @(negedge clock);
    reset = rst; in_wb_act = wa; in_wb_res = wr; in_wb_reg_idx = wi;
    in_mc_valid = mv; in_mc_res = mr; in_mc_reg_idx = mi;
    #1;
    e_pend = (mcq.size() != 0);
    gwb = 1'b0; gmc = 1'b0;
    if (rst) begin
      e_rdy = 1'b0; e_stl = 1'b0;
    end else begin
      e_rdy = (mcq.size() < DEPTH);
      if (forcing) gmc = (mcq.size() > 0);
      else if (wa) begin
        gwb = 1'b1;
        if (mcq.size() > 0) begin
          if (mcq[0].i == wi) begin gmc = 1'b1; gwb = 1'b0; end
        end
      end else gmc = (mcq.size() > 0);
      e_stl = wa && !gwb;
    end
    dut_stall = out_wb_stall; dut_rdy = out_mc_ready; dut_pend = out_mc_pending;
    chk("ready", 32'(out_mc_ready), 32'(e_rdy));
    chk("stall", 32'(out_wb_stall), 32'(e_stl));
    chk("pending", 32'(out_mc_pending), 32'(e_pend));
    if (rst) begin
      mcq.delete(); streak = 0; forcing = 0;
    end else begin
      if (gwb) exp_q.push_back('{wr, wi, edge_cnt + 1});
      if (gmc) exp_q.push_back('{mcq[0].d, mcq[0].i, edge_cnt + 1});
      if (mcq.size() == 0 || gmc) streak = 0;
      else if (streak < LIM) streak++;
      forcing = !forcing && (streak == LIM);
      if (gmc) void'(mcq.pop_front());
      if (mv && e_rdy) mcq.push_back('{mr, mi});
    end
    stl = e_stl; rdy = e_rdy;
  endtask

  task automatic idle(input int n);
    logic s, r;
    for (int k = 0; k < n; k++) step(0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, s, r);
  endtask

  initial begin
    logic s, r;
    int stall_cnt;
    logic        wa, mv;
    logic [15:0] wr, mr;
    logic [3:0]  wi, mi;
    total = 0; bad = 0; edge_cnt = 0; streak = 0; forcing = 0;
    reset = 1; in_wb_act = 0; in_wb_res = 0; in_wb_reg_idx = 0;
    in_mc_valid = 0; in_mc_res = 0; in_mc_reg_idx = 0;

    step(1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, s, r);
    step(1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, s, r);
    idle(2);

    // Writeback only
    step(0, 1, 16'h1234, 4'd3, 0, 16'h0, 4'h0, s, r);
    @(posedge clock); #2;
    chk("wb_only_we", 32'(out_rf_we), 32'd1);
    chk("wb_only_data", 32'(out_rf_data), 32'h1234);
    chk("wb_only_idx", 32'(out_rf_idx), 32'd3);
    idle(2);

    // Multi-cycle only
    step(0, 0, 16'h0, 4'h0, 1, 16'hBEEF, 4'd5, s, r);
    idle(1);
    @(posedge clock); #2;
    chk("mc_only_data", 32'(out_rf_data), 32'hBEEF);
    chk("mc_only_idx", 32'(out_rf_idx), 32'd5);
    idle(2);

    // Starvation: head idx 9 vs writeback idx 1 every cycle
    step(0, 1, 16'h1000, 4'd1, 1, 16'h9999, 4'd9, s, r);
    stall_cnt = 0;
    wr = 16'h1001;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, wr, 4'd1, 0, 16'h0, 4'h0, s, r);
      if (dut_stall) stall_cnt++;
      if (!s) wr++;
    end
    chk("starve_stalls", 32'(stall_cnt), 32'd1);
    idle(3);

    // WAW on register 7
    step(0, 0, 16'h0, 4'h0, 1, 16'h0001, 4'd7, s, r);
    step(0, 1, 16'h0002, 4'd7, 0, 16'h0, 4'h0, s, r);
    chk("waw_stall", 32'(dut_stall), 32'd1);
    step(0, 1, 16'h0002, 4'd7, 0, 16'h0, 4'h0, s, r);
    chk("waw_resume", 32'(dut_stall), 32'd0);
    idle(3);

    // Full: writeback busy, offers held until accepted
    wr = 16'h2000; mr = 16'hA000;
    for (int k = 0; k < 12; k++) begin
      step(0, 1, wr, 4'd1, (k < 8), mr, 4'(8 + k % 2), s, r);
      if (k == 2) chk("full_ready", 32'(dut_rdy), 32'd0);
      if (!s) wr++;
      if (r && k < 8) mr++;
    end
    idle(6);

    // Reset mid-operation with two entries pending
    step(0, 1, 16'h3000, 4'd1, 1, 16'hC001, 4'd10, s, r);
    step(0, 1, 16'h3001, 4'd1, 1, 16'hC002, 4'd11, s, r);
    step(1, 1, 16'h3002, 4'd1, 0, 16'h0, 4'h0, s, r);
    idle(1);
    chk("rst_pending", 32'(dut_pend), 32'd0);
    idle(4);

    // Randomized traffic with hold-while-stalled / hold-until-ready upstreams
    wa = 0; wr = 0; wi = 0; mv = 0; mr = 0; mi = 0;
    for (int k = 0; k < 1500; k++) begin
      logic rr;
      rr = ($urandom_range(0, 99) == 0);
      step(rr, wa, wr, wi, mv, mr, mi, s, r);
      if (rr || !s) begin
        wa = ($urandom_range(0, 99) < 60);
        wr = 16'($urandom); wi = 4'($urandom_range(0, 7));
      end
      if (rr || !mv || r) begin
        mv = ($urandom_range(0, 99) < 40);
        mr = 16'($urandom); mi = 4'($urandom_range(0, 7));
      end
    end
    idle(12);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
